// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, FSM state codes and counter width for the multiply/divide unit
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int CNT_W     = $clog2(MDU_WIDTH);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum     = acc + {1'b0, m};
        shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, m};
        acc_nxt = acc;
        q_nxt   = q;
        if (!is_div) begin
            // multiplier bits leave q from the bottom while product bits enter from the top
            if (q[0]) begin
                acc_nxt = {1'b0, sum[WIDTH:1]};
                q_nxt   = {sum[0], q[WIDTH-1:1]};
            end else begin
                acc_nxt = {1'b0, acc[WIDTH:1]};
                q_nxt   = {acc[0], q[WIDTH-1:1]};
            end
        end else if (!diff[WIDTH+1]) begin
            acc_nxt = diff[WIDTH:0];
            q_nxt   = {q[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = shifted;
            q_nxt   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [1:0]       op_r;
    logic             sa, sb;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   acc, acc_nxt;
    logic [WIDTH-1:0] q, q_nxt;

    logic             signed_op;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign busy = (state != ST_IDLE);

    always_comb begin
        signed_op = ~op[0];
        mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
        mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_r[1]),
        .acc     (acc),
        .q       (q),
        .m       (m),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt)
    );

    // sign fix: sa/sb are only ever set for the signed ops
    always_comb begin
        prod   = {acc[WIDTH-1:0], q};
        rem    = acc[WIDTH-1:0];
        res_hi = '0;
        res_lo = '0;
        if (!op_r[1]) begin
            {res_hi, res_lo} = (sa ^ sb) ? -prod : prod;
        end else if (m == '0) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_lo = (sa ^ sb) ? -q : q;
            res_hi = sa ? -rem : rem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
            op_r  <= OP_MULT;
            sa    <= 1'b0;
            sb    <= 1'b0;
            a_raw <= '0;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        state <= ST_CALC;
                        count <= '0;
                        op_r  <= op;
                        sa    <= signed_op & a[WIDTH-1];
                        sb    <= signed_op & b[WIDTH-1];
                        a_raw <= a;
                        m     <= op[1] ? mag_b : mag_a;
                        q     <= op[1] ? mag_a : mag_b;
                        acc   <= '0;
                    end else if (!start) begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                ST_CALC: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        acc   <= acc_nxt;
                        q     <= q_nxt;
                        count <= count + 1'b1;
                        if (count == CNT_W'(WIDTH - 1)) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!cancel) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - table-driven and sequence checks for mdu_iterative
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, cancel, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy;
    logic [31:0] hi, lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    mdu_iterative dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdata  (wdata),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Launch an op at a negedge, scramble inputs afterwards, and count busy cycles.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit poke, input bit wr_with_start, output int cyc);
        op = o; a = x; b = y; start = 1'b1;
        mthi = wr_with_start; mtlo = wr_with_start; wdata = 32'd9;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        a = 32'h5A5A_0F0F; b = 32'h0000_0000; op = ~o;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (poke && cyc == 5) begin
                start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'd7,          32'h0000_0006, 32'hFFFF_FFEB};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd7,         32'd2,          32'h0000_0001, 32'h0000_0003};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{2'b11, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF};
        vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9] = '{2'b10, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF};

        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, cyc);
            check($sformatf("vec%0d_cycles", i), cyc, 33);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // start and mthi during busy are ignored; result and latency unchanged
        run_op(2'b01, 32'd3, 32'd5, 1'b1, 1'b0, cyc);
        check("poke_cycles", cyc, 33);
        check("poke_hi", hi, 32'd0);
        check("poke_lo", lo, 32'd15);

        // MTHI then MTLO on separate cycles
        mthi = 1'b1; wdata = 32'hAA; @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'hBB; @(negedge clk);
        mtlo = 1'b0;
        check("mthi_hi", hi, 32'hAA);
        check("mtlo_lo", lo, 32'hBB);

        // cancel mid-CALC
        op = 2'b01; a = 32'd100; b = 32'd200; start = 1'b1; @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("cancel_pre_busy", {31'b0, busy}, 32'd1);
        cancel = 1'b1; @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {31'b0, busy}, 32'd0);
        check("cancel_hi", hi, 32'hAA);
        check("cancel_lo", lo, 32'hBB);

        // cancel coinciding with the FIX cycle still blocks the write
        op = 2'b01; a = 32'd100; b = 32'd200; start = 1'b1; @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        check("fixcancel_pre_busy", {31'b0, busy}, 32'd1);
        cancel = 1'b1; @(negedge clk);
        cancel = 1'b0;
        check("fixcancel_busy", {31'b0, busy}, 32'd0);
        check("fixcancel_hi", hi, 32'hAA);
        check("fixcancel_lo", lo, 32'hBB);

        // cancel and start together in IDLE: start dropped
        start = 1'b1; cancel = 1'b1; @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel_start_busy", {31'b0, busy}, 32'd0);

        // MTHI and MTLO together
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'd5; @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_hi", hi, 32'd5);
        check("mthilo_lo", lo, 32'd5);

        // start wins over mthi/mtlo in the same IDLE cycle
        run_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b1, cyc);
        check("startwr_cycles", cyc, 33);
        check("startwr_hi", hi, 32'd0);
        check("startwr_lo", lo, 32'd6);

        // asynchronous reset in the middle of CALC
        op = 2'b00; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1; @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_lo", lo, 32'd6);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_busy", {31'b0, busy}, 32'd0);
        check("async_reset_hi", hi, 32'd0);
        check("async_reset_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
